rv32_decode: RTL and testbench
==============================

RV32_DECODE -- requirements
Module: rv32_decode

Interface
REQ-001 Parameter: DATA_WIDTH, 32, width of pc, imm and pcOut.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rstN  input  1  asynchronous active-low reset.
REQ-004 instrValid  input  1  fetch presents instr/pc.
REQ-005 instrReady  output  1  stage can accept.
REQ-006 instr  input  32  RV32I instruction word.
REQ-007 pc  input  DATA_WIDTH  address of instr.
REQ-008 flush  input  1  discard held and incoming instruction.
REQ-009 decValid  output  1  decoded bundle valid.
REQ-010 decReady  input  1  execute stage accepts bundle.
REQ-011 aluOp  output  4  ALU code: EQ=0 NE=1 LT=2 GE=3 LTU=4 GEU=5 ADD=6 XOR=7 OR=8 AND=9 SUB=10 SLL=11 SRL=12 SRA=13.
REQ-012 rs1Addr, rs2Addr, rdAddr  output  5 each  register indices.
REQ-013 imm  output  DATA_WIDTH  sign-extended immediate.
REQ-014 useImm, usePc, regWrite, isBranch, isJump, isLoad, isStore, isSetLess, illegal  output  1 each  control flags.
REQ-015 memSize  output  3  funct3 of load/store, else 0.
REQ-016 pcOut  output  DATA_WIDTH  pc of decoded instruction.

Function
REQ-017 Transfer in occurs when instrValid && instrReady; transfer out when decValid && decReady.
REQ-018 instrReady SHALL equal !decValid || decReady (combinational); no bubble under continuous flow.
REQ-019 Latency: bundle registered, decValid asserted the cycle after input transfer.
REQ-020 While decValid && !decReady, all outputs SHALL hold stable.
REQ-021 flush SHALL clear decValid next cycle and suppress same-cycle input transfer; flush has priority over transfer.
REQ-022 OP (0110011): funct7 0000000 -> ADD/SLL/LT/LTU/XOR/SRL/OR/AND by funct3; funct7 0100000 with funct3 000 -> SUB, 101 -> SRA; else illegal.
REQ-023 OP-IMM (0010011): same funct3 map, useImm=1; funct3 001 requires funct7 0000000; 101 takes SRL/SRA by funct7; other funct7 illegal.
REQ-024 SLT/SLTI/SLTU/SLTIU SHALL set isSetLess=1 (writeback uses result bit 0).
REQ-025 BRANCH (1100011): funct3 000/001/100/101/110/111 -> EQ/NE/LT/GE/LTU/GEU, isBranch=1, B-imm; 010/011 illegal.
REQ-026 LOAD/STORE: aluOp=ADD, useImm=1, I-/S-imm, memSize=funct3; load funct3 in {000,001,010,100,101}, store in {000,001,010}, else illegal.
REQ-027 LUI: aluOp=ADD, rs1Addr=0, useImm=1, U-imm; AUIPC: ADD, usePc=1, useImm=1, U-imm.
REQ-028 JAL: isJump=1, usePc=1, J-imm; JALR (funct3 000): isJump=1, I-imm; both regWrite=1, aluOp=ADD.
REQ-029 regWrite SHALL be 0 when rdAddr=0, for BRANCH/STORE, or when illegal=1.
REQ-030 Illegal or unknown opcode: illegal=1, all other flags 0, aluOp=ADD, bundle still delivered with pcOut.

Reset
REQ-031 rstN low SHALL immediately force decValid=0 and all registered outputs to 0, independent of clk.
REQ-032 Reset mid-stall SHALL discard the held bundle; first transfer allowed the first edge after rstN rises.

Structure
REQ-033 aluOp codes, opcode constants and funct3/funct7 constants SHALL live in the shared core package, also used by the ALU.
REQ-034 Combinational decode SHALL be one sub-module, rv32_imm_gen (instr -> imm per format); stage register and handshake stay in rv32_decode.

Verification
REQ-035 instr 0x00500093 (addi x1,x0,5), decReady=1 -> next cycle decValid=1, aluOp=6, rdAddr=1, imm=5, useImm=1, regWrite=1.
REQ-036 instr 0x40208033 (sub x0,x1,x2) -> aluOp=10, rs1Addr=1, rs2Addr=2, regWrite=0.
REQ-037 instr 0xFE208EE3 (beq x1,x2,-4) -> aluOp=0, imm=0xFFFFFFFC, isBranch=1, regWrite=0.
REQ-038 decReady=0 for 3 cycles with decValid=1 -> instrReady=0, outputs unchanged; decReady=1 -> new instr accepted same cycle.
REQ-039 instr 0x0000007F -> illegal=1, regWrite=0; flush during stall -> decValid=0 next cycle, no input consumed.
REQ-040 rstN pulsed low mid-stall -> decValid=0 immediately, instrReady=1 after release.

Source files
------------

// File: rtl/rv32_decode_pkg.sv
// Shared RV32I core definitions: ALU codes, opcodes, funct fields.
// Also holds the decoded bundle type passed from decode to execute.
package rv32_decode_pkg;

    typedef enum logic [3:0] {
        ALU_EQ  = 4'd0,
        ALU_NE  = 4'd1,
        ALU_LT  = 4'd2,
        ALU_GE  = 4'd3,
        ALU_LTU = 4'd4,
        ALU_GEU = 4'd5,
        ALU_ADD = 4'd6,
        ALU_XOR = 4'd7,
        ALU_OR  = 4'd8,
        ALU_AND = 4'd9,
        ALU_SUB = 4'd10,
        ALU_SLL = 4'd11,
        ALU_SRL = 4'd12,
        ALU_SRA = 4'd13
    } alu_op_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        alu_op_t     aluOp;
        logic [4:0]  rs1Addr;
        logic [4:0]  rs2Addr;
        logic [4:0]  rdAddr;
        logic [31:0] imm;
        logic        useImm;
        logic        usePc;
        logic        regWrite;
        logic        isBranch;
        logic        isJump;
        logic        isLoad;
        logic        isStore;
        logic        isSetLess;
        logic        illegal;
        logic [2:0]  memSize;
    } dec_t;

    function automatic alu_op_t arith_op(input logic [2:0] f3);
        arith_op = ALU_ADD;
        unique case (f3)
            F3_ADD:  arith_op = ALU_ADD;
            F3_SLL:  arith_op = ALU_SLL;
            F3_SLT:  arith_op = ALU_LT;
            F3_SLTU: arith_op = ALU_LTU;
            F3_XOR:  arith_op = ALU_XOR;
            F3_SR:   arith_op = ALU_SRL;
            F3_OR:   arith_op = ALU_OR;
            F3_AND:  arith_op = ALU_AND;
        endcase
    endfunction

    function automatic alu_op_t branch_op(input logic [2:0] f3);
        branch_op = ALU_EQ;
        unique case (f3)
            3'b000:  branch_op = ALU_EQ;
            3'b001:  branch_op = ALU_NE;
            3'b100:  branch_op = ALU_LT;
            3'b101:  branch_op = ALU_GE;
            3'b110:  branch_op = ALU_LTU;
            3'b111:  branch_op = ALU_GEU;
            default: branch_op = ALU_EQ;
        endcase
    endfunction

endpackage

// File: rtl/rv32_imm_gen.sv
// Combinational RV32I decode: control fields plus per-format immediate.
// Illegal encodings collapse to a flag-free ADD bundle.
module rv32_imm_gen
    import rv32_decode_pkg::*;
(
    input  logic [31:0] instr,
    output dec_t        dec
);

    logic [6:0]  op;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] immI, immS, immB, immU, immJ;
    logic        ill;
    logic        wr;

    assign op = instr[6:0];
    assign f3 = instr[14:12];
    assign f7 = instr[31:25];

    assign immI = {{20{instr[31]}}, instr[31:20]};
    assign immS = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign immB = {{19{instr[31]}}, instr[31], instr[7],
                   instr[30:25], instr[11:8], 1'b0};
    assign immU = {instr[31:12], 12'b0};
    assign immJ = {{11{instr[31]}}, instr[31], instr[19:12],
                   instr[20], instr[30:21], 1'b0};

    always_comb begin
        dec         = '0;
        dec.aluOp   = ALU_ADD;
        dec.rs1Addr = instr[19:15];
        dec.rs2Addr = instr[24:20];
        dec.rdAddr  = instr[11:7];
        ill         = 1'b0;
        wr          = 1'b0;
        unique case (1'b1)
            (op == OPC_OP): begin
                wr = 1'b1;
                dec.isSetLess = (f3 == F3_SLT) || (f3 == F3_SLTU);
                if (f7 == F7_BASE) dec.aluOp = arith_op(f3);
                else if (f7 == F7_ALT && f3 == F3_ADD) dec.aluOp = ALU_SUB;
                else if (f7 == F7_ALT && f3 == F3_SR) dec.aluOp = ALU_SRA;
                else ill = 1'b1;
            end
            (op == OPC_OPIMM): begin
                wr = 1'b1;
                dec.useImm = 1'b1;
                dec.imm = immI;
                dec.aluOp = arith_op(f3);
                dec.isSetLess = (f3 == F3_SLT) || (f3 == F3_SLTU);
                // Only shifts reuse funct7; other funct3 carry imm bits there
                if (f3 == F3_SLL && f7 != F7_BASE) ill = 1'b1;
                if (f3 == F3_SR) begin
                    if (f7 == F7_ALT) dec.aluOp = ALU_SRA;
                    else if (f7 != F7_BASE) ill = 1'b1;
                end
            end
            (op == OPC_BRANCH): begin
                dec.isBranch = 1'b1;
                dec.imm = immB;
                dec.aluOp = branch_op(f3);
                ill = (f3 == 3'b010) || (f3 == 3'b011);
            end
            (op == OPC_LOAD): begin
                wr = 1'b1;
                dec.useImm = 1'b1;
                dec.isLoad = 1'b1;
                dec.imm = immI;
                dec.memSize = f3;
                ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            (op == OPC_STORE): begin
                dec.useImm = 1'b1;
                dec.isStore = 1'b1;
                dec.imm = immS;
                dec.memSize = f3;
                ill = f3[2] || (f3 == 3'b011);
            end
            (op == OPC_LUI): begin
                wr = 1'b1;
                dec.rs1Addr = 5'd0;
                dec.useImm = 1'b1;
                dec.imm = immU;
            end
            (op == OPC_AUIPC): begin
                wr = 1'b1;
                dec.usePc = 1'b1;
                dec.useImm = 1'b1;
                dec.imm = immU;
            end
            (op == OPC_JAL): begin
                wr = 1'b1;
                dec.isJump = 1'b1;
                dec.usePc = 1'b1;
                dec.imm = immJ;
            end
            (op == OPC_JALR): begin
                wr = 1'b1;
                dec.isJump = 1'b1;
                dec.imm = immI;
                ill = (f3 != 3'b000);
            end
            default: ill = 1'b1;
        endcase
        if (ill) begin
            dec.aluOp     = ALU_ADD;
            dec.imm       = '0;
            dec.useImm    = 1'b0;
            dec.usePc     = 1'b0;
            dec.isBranch  = 1'b0;
            dec.isJump    = 1'b0;
            dec.isLoad    = 1'b0;
            dec.isStore   = 1'b0;
            dec.isSetLess = 1'b0;
            dec.memSize   = 3'd0;
            dec.illegal   = 1'b1;
        end
        dec.regWrite = wr && !ill && (dec.rdAddr != 5'd0);
    end

endmodule

// File: rtl/rv32_decode.sv
// RV32I decode stage: valid/ready skid-free register around rv32_imm_gen.
// Flush beats input transfer; async reset empties the stage.
module rv32_decode
    import rv32_decode_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  instrValid,
    output logic                  instrReady,
    input  logic [31:0]           instr,
    input  logic [DATA_WIDTH-1:0] pc,
    input  logic                  flush,
    output logic                  decValid,
    input  logic                  decReady,
    output logic [3:0]            aluOp,
    output logic [4:0]            rs1Addr,
    output logic [4:0]            rs2Addr,
    output logic [4:0]            rdAddr,
    output logic [DATA_WIDTH-1:0] imm,
    output logic                  useImm,
    output logic                  usePc,
    output logic                  regWrite,
    output logic                  isBranch,
    output logic                  isJump,
    output logic                  isLoad,
    output logic                  isStore,
    output logic                  isSetLess,
    output logic                  illegal,
    output logic [2:0]            memSize,
    output logic [DATA_WIDTH-1:0] pcOut
);

    dec_t                  dec;
    dec_t                  held;
    logic [DATA_WIDTH-1:0] pcHeld;
    logic                  take;

    rv32_imm_gen u_imm_gen (
        .instr (instr),
        .dec   (dec)
    );

    assign instrReady = !decValid || decReady;
    assign take       = instrValid && instrReady && !flush;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            decValid <= 1'b0;
            held     <= '0;
            pcHeld   <= '0;
        end else if (flush) begin
            decValid <= 1'b0;
        end else if (take) begin
            decValid <= 1'b1;
            held     <= dec;
            pcHeld   <= pc;
        end else if (decReady) begin
            decValid <= 1'b0;
        end
    end

    assign aluOp     = held.aluOp;
    assign rs1Addr   = held.rs1Addr;
    assign rs2Addr   = held.rs2Addr;
    assign rdAddr    = held.rdAddr;
    assign imm       = DATA_WIDTH'($signed(held.imm));
    assign useImm    = held.useImm;
    assign usePc     = held.usePc;
    assign regWrite  = held.regWrite;
    assign isBranch  = held.isBranch;
    assign isJump    = held.isJump;
    assign isLoad    = held.isLoad;
    assign isStore   = held.isStore;
    assign isSetLess = held.isSetLess;
    assign illegal   = held.illegal;
    assign memSize   = held.memSize;
    assign pcOut     = pcHeld;

endmodule

// File: tb/tb_rv32_decode.sv
// Bench for rv32_decode: directed encodings, stall/flush/reset, and a
// randomized stream scored against an arithmetic reference decoder.
module tb_rv32_decode;

    logic        clk = 1'b0;
    logic        rstN;
    logic        instrValid;
    logic        instrReady;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        flush;
    logic        decValid;
    logic        decReady;
    logic [3:0]  aluOp;
    logic [4:0]  rs1Addr, rs2Addr, rdAddr;
    logic [31:0] imm;
    logic        useImm, usePc, regWrite, isBranch, isJump;
    logic        isLoad, isStore, isSetLess, illegal;
    logic [2:0]  memSize;
    logic [31:0] pcOut;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [3:0]  alu;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm;
        logic        useImm, usePc, regWrite, isBranch, isJump;
        logic        isLoad, isStore, isSetLess, illegal;
        logic [2:0]  memSize;
        logic [31:0] pc;
    } exp_t;

    localparam logic [3:0] ALU_MAP [8] = '{4'd6, 4'd11, 4'd2, 4'd4,
                                           4'd7, 4'd12, 4'd8, 4'd9};
    localparam logic [3:0] BR_MAP [8] = '{4'd0, 4'd1, 4'd15, 4'd15,
                                          4'd2, 4'd3, 4'd4, 4'd5};
    localparam logic [6:0] OPS [11] = '{7'h33, 7'h13, 7'h63, 7'h03,
                                        7'h23, 7'h37, 7'h17, 7'h6F,
                                        7'h67, 7'h0F, 7'h73};

    rv32_decode #(.DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rstN       (rstN),
        .instrValid (instrValid),
        .instrReady (instrReady),
        .instr      (instr),
        .pc         (pc),
        .flush      (flush),
        .decValid   (decValid),
        .decReady   (decReady),
        .aluOp      (aluOp),
        .rs1Addr    (rs1Addr),
        .rs2Addr    (rs2Addr),
        .rdAddr     (rdAddr),
        .imm        (imm),
        .useImm     (useImm),
        .usePc      (usePc),
        .regWrite   (regWrite),
        .isBranch   (isBranch),
        .isJump     (isJump),
        .isLoad     (isLoad),
        .isStore    (isStore),
        .isSetLess  (isSetLess),
        .illegal    (illegal),
        .memSize    (memSize),
        .pcOut      (pcOut)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [31:0] w,
                                   input logic [31:0] p);
        exp_t        e;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] iimm, simm, bimm, uimm, jimm;
        bit          ill;
        bit          wr;
        e = '0;
        op = w[6:0];
        f3 = w[14:12];
        f7 = w[31:25];
        iimm = 32'($signed(w) >>> 20);
        simm = (iimm & ~32'h1F) | 32'(w[11:7]);
        bimm = (w[31] ? 32'hFFFFF000 : 32'h0) + (32'(w[7]) << 11)
             + (32'(w[30:25]) << 5) + (32'(w[11:8]) << 1);
        uimm = w & 32'hFFFFF000;
        jimm = (w[31] ? 32'hFFF00000 : 32'h0) + (32'(w[19:12]) << 12)
             + (32'(w[20]) << 11) + (32'(w[30:21]) << 1);
        e.rs1 = w[19:15];
        e.rs2 = w[24:20];
        e.rd  = w[11:7];
        e.alu = 4'd6;
        e.pc  = p;
        ill = 0;
        wr  = 0;
        case (op)
            7'h33: begin
                wr = 1;
                e.isSetLess = (f3 == 2 || f3 == 3);
                if (f7 == 0) e.alu = ALU_MAP[f3];
                else if (f7 == 7'h20 && f3 == 0) e.alu = 4'd10;
                else if (f7 == 7'h20 && f3 == 5) e.alu = 4'd13;
                else ill = 1;
            end
            7'h13: begin
                wr = 1;
                e.useImm = 1;
                e.imm = iimm;
                e.alu = ALU_MAP[f3];
                e.isSetLess = (f3 == 2 || f3 == 3);
                if (f3 == 1 && f7 != 0) ill = 1;
                if (f3 == 5 && f7 == 7'h20) e.alu = 4'd13;
                if (f3 == 5 && f7 != 7'h20 && f7 != 0) ill = 1;
            end
            7'h63: begin
                e.isBranch = 1;
                e.imm = bimm;
                e.alu = BR_MAP[f3];
                if (BR_MAP[f3] == 4'd15) ill = 1;
            end
            7'h03: begin
                wr = 1;
                e.useImm = 1;
                e.isLoad = 1;
                e.imm = iimm;
                e.memSize = f3;
                if (f3 == 3 || f3 == 6 || f3 == 7) ill = 1;
            end
            7'h23: begin
                e.useImm = 1;
                e.isStore = 1;
                e.imm = simm;
                e.memSize = f3;
                if (f3 > 2) ill = 1;
            end
            7'h37: begin
                wr = 1;
                e.rs1 = 0;
                e.useImm = 1;
                e.imm = uimm;
            end
            7'h17: begin
                wr = 1;
                e.usePc = 1;
                e.useImm = 1;
                e.imm = uimm;
            end
            7'h6F: begin
                wr = 1;
                e.isJump = 1;
                e.usePc = 1;
                e.imm = jimm;
            end
            7'h67: begin
                wr = 1;
                e.isJump = 1;
                e.imm = iimm;
                if (f3 != 0) ill = 1;
            end
            default: ill = 1;
        endcase
        if (ill) begin
            e.alu = 4'd6;
            e.imm = 0;
            {e.useImm, e.usePc, e.isBranch, e.isJump} = '0;
            {e.isLoad, e.isStore, e.isSetLess} = '0;
            e.memSize = 0;
            e.illegal = 1;
        end
        e.regWrite = wr && !ill && (e.rd != 0);
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        w[6:0] = OPS[$urandom_range(0, 10)];
        if ($urandom_range(0, 3) != 0)
            w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        return w;
    endfunction

    task automatic send(input logic [31:0] w, input logic [31:0] p);
        @(negedge clk);
        instrValid = 1'b1;
        instr = w;
        pc = p;
        decReady = 1'b1;
        flush = 1'b0;
        @(posedge clk);
        #1;
        instrValid = 1'b0;
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        instrValid = 1'b0;
        instr = '0;
        pc = '0;
        flush = 1'b0;
        decReady = 1'b0;
        #2;
        checks++;
        if (decValid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b expected 0", decValid);
        end
        checks++;
        if (instrReady !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 1", instrReady);
        end
        checks++;
        if ({aluOp, imm, regWrite, pcOut} !== '0) begin
            errors++;
            $display("FAIL reset_regs: alu=%0d imm=%h pc=%h expected 0",
                     aluOp, imm, pcOut);
        end
        @(negedge clk);
        rstN = 1'b1;
    endtask

    task automatic test_addi();
        send(32'h00500093, 32'h100);
        checks++;
        if ({decValid, aluOp, rdAddr, imm, useImm, regWrite, pcOut} !==
            {1'b1, 4'd6, 5'd1, 32'd5, 1'b1, 1'b1, 32'h100}) begin
            errors++;
            $display("FAIL addi: v=%b alu=%0d rd=%0d imm=%h ui=%b rw=%b pc=%h expected 1 6 1 5 1 1 100",
                     decValid, aluOp, rdAddr, imm, useImm, regWrite, pcOut);
        end
    endtask

    task automatic test_sub();
        send(32'h40208033, 32'h104);
        checks++;
        if ({decValid, aluOp, rs1Addr, rs2Addr, regWrite} !==
            {1'b1, 4'd10, 5'd1, 5'd2, 1'b0}) begin
            errors++;
            $display("FAIL sub: v=%b alu=%0d rs1=%0d rs2=%0d rw=%b expected 1 10 1 2 0",
                     decValid, aluOp, rs1Addr, rs2Addr, regWrite);
        end
    endtask

    task automatic test_beq();
        send(32'hFE208EE3, 32'h108);
        checks++;
        if ({decValid, aluOp, imm, isBranch, regWrite} !==
            {1'b1, 4'd0, 32'hFFFFFFFC, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL beq: v=%b alu=%0d imm=%h br=%b rw=%b expected 1 0 fffffffc 1 0",
                     decValid, aluOp, imm, isBranch, regWrite);
        end
    endtask

    task automatic test_stall();
        send(32'h00500093, 32'h200);
        @(negedge clk);
        decReady = 1'b0;
        instrValid = 1'b1;
        instr = 32'h40208033;
        pc = 32'h204;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({instrReady, decValid, aluOp, imm, pcOut} !==
                {1'b0, 1'b1, 4'd6, 32'd5, 32'h200}) begin
                errors++;
                $display("FAIL stall_hold%0d: rdy=%b v=%b alu=%0d imm=%h pc=%h expected 0 1 6 5 200",
                         i, instrReady, decValid, aluOp, imm, pcOut);
            end
        end
        @(negedge clk);
        decReady = 1'b1;
        #1;
        checks++;
        if (instrReady !== 1'b1) begin
            errors++;
            $display("FAIL stall_release_ready: got %b expected 1", instrReady);
        end
        @(posedge clk);
        #1;
        instrValid = 1'b0;
        checks++;
        if ({decValid, aluOp, pcOut} !== {1'b1, 4'd10, 32'h204}) begin
            errors++;
            $display("FAIL stall_accept: v=%b alu=%0d pc=%h expected 1 10 204",
                     decValid, aluOp, pcOut);
        end
    endtask

    task automatic test_illegal_flush();
        send(32'h0000007F, 32'h300);
        checks++;
        if ({decValid, illegal, regWrite, aluOp, pcOut} !==
            {1'b1, 1'b1, 1'b0, 4'd6, 32'h300}) begin
            errors++;
            $display("FAIL illegal: v=%b ill=%b rw=%b alu=%0d pc=%h expected 1 1 0 6 300",
                     decValid, illegal, regWrite, aluOp, pcOut);
        end
        @(negedge clk);
        decReady = 1'b0;
        instrValid = 1'b1;
        instr = 32'h00500093;
        flush = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (decValid !== 1'b0) begin
            errors++;
            $display("FAIL flush_stall: decValid got %b expected 0", decValid);
        end
        @(negedge clk);
        flush = 1'b1;
        decReady = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (decValid !== 1'b0) begin
            errors++;
            $display("FAIL flush_suppress: decValid got %b expected 0", decValid);
        end
        @(negedge clk);
        flush = 1'b0;
        instrValid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (decValid !== 1'b0) begin
            errors++;
            $display("FAIL flush_noconsume: decValid got %b expected 0", decValid);
        end
    endtask

    task automatic test_reset_midstall();
        send(32'h00500093, 32'h400);
        @(negedge clk);
        decReady = 1'b0;
        @(posedge clk);
        #3;
        rstN = 1'b0;
        #1;
        checks++;
        if ({decValid, instrReady, imm, aluOp} !== {1'b0, 1'b1, 32'd0, 4'd0}) begin
            errors++;
            $display("FAIL reset_midstall: v=%b rdy=%b imm=%h alu=%0d expected 0 1 0 0",
                     decValid, instrReady, imm, aluOp);
        end
        @(negedge clk);
        rstN = 1'b1;
        instrValid = 1'b1;
        instr = 32'h40208033;
        pc = 32'h404;
        decReady = 1'b1;
        @(posedge clk);
        #1;
        instrValid = 1'b0;
        checks++;
        if ({decValid, aluOp, pcOut} !== {1'b1, 4'd10, 32'h404}) begin
            errors++;
            $display("FAIL reset_first_xfer: v=%b alu=%0d pc=%h expected 1 10 404",
                     decValid, aluOp, pcOut);
        end
    endtask

    task automatic test_random();
        exp_t m;
        exp_t act;
        logic mv;
        logic rdy;
        m = '0;
        @(negedge clk);
        instrValid = 1'b0;
        flush = 1'b1;
        decReady = 1'b1;
        @(posedge clk);
        mv = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            instrValid = ($urandom_range(0, 3) != 0);
            instr = rand_instr();
            pc = $urandom & 32'hFFFFFFFC;
            decReady = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 19) == 0);
            #1;
            checks++;
            if (instrReady !== (!mv || decReady)) begin
                errors++;
                $display("FAIL rand_ready[%0d]: got %b expected %b",
                         i, instrReady, !mv || decReady);
            end
            @(posedge clk);
            rdy = !mv || decReady;
            if (flush) mv = 1'b0;
            else if (instrValid && rdy) begin
                mv = 1'b1;
                m = model(instr, pc);
            end else if (decReady) mv = 1'b0;
            #1;
            checks++;
            if (decValid !== mv) begin
                errors++;
                $display("FAIL rand_valid[%0d]: got %b expected %b",
                         i, decValid, mv);
            end
            if (mv) begin
                act = {aluOp, rs1Addr, rs2Addr, rdAddr, imm, useImm, usePc,
                       regWrite, isBranch, isJump, isLoad, isStore,
                       isSetLess, illegal, memSize, pcOut};
                checks++;
                if (act !== m) begin
                    errors++;
                    $display("FAIL rand_bundle[%0d]: got %h expected %h",
                             i, act, m);
                end
            end
        end
        @(negedge clk);
        instrValid = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_sub();
        test_beq();
        test_stall();
        test_illegal_flush();
        test_reset_midstall();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
